// File: rtl/inet_csum_stream.sv
// Streaming 16-bit ones-complement (Internet) checksum over LANES x 16-bit words per beat.
// Optional `INET_CSUM_CHECK_EN adds csum_ok (stream carries a correct checksum field).
module inet_csum_stream #(
   parameter int unsigned LANES = 4,
   parameter int unsigned ACC_W = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [16*LANES-1:0]   in_data,
   input  logic [LANES-1:0]      in_keep,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   input  logic [15:0]           init_value,
   output logic [15:0]           csum,
   output logic                  csum_valid,
   input  logic                  csum_ready
`ifdef INET_CSUM_CHECK_EN
   ,
   output logic                  csum_ok
`endif
);

   localparam int unsigned LS_W = 16 + $clog2(LANES);
   localparam int unsigned NCH  = (ACC_W + 15) / 16;

   typedef enum logic [2:0] {ACCUM, DRAIN, FOLD1, FOLD2, DONE} state_t;

   state_t            state_q;
   logic              in_ready_q;
   logic              first_q;
   logic              lane_vld_q;
   logic [LS_W-1:0]   lane_sum_q;
   logic [LS_W-1:0]   lane_sum_d;
   logic [15:0]       init_q;
   logic [ACC_W-1:0]  acc_q;
   logic [ACC_W-1:0]  acc_d;
   logic [ACC_W:0]    acc_sum;
   logic [ACC_W-1:0]  fold_x;
   logic [16:0]       s1_q;
   logic [16:0]       s1_d;
   logic [15:0]       s2;
   logic [15:0]       csum_q;
   logic              csum_valid_q;
`ifdef INET_CSUM_CHECK_EN
   logic              csum_ok_q;
`endif
   logic              accept;

   assign accept = in_valid && in_ready_q;

   always_comb begin
      lane_sum_d = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (in_keep[k]) lane_sum_d = lane_sum_d + LS_W'(in_data[16*k +: 16]);
      end
   end

   // Sum cannot exceed 2^(ACC_W+1), so one end-around add of the carry is exact.
   always_comb begin
      acc_sum = {1'b0, acc_q} + (ACC_W+1)'(lane_sum_q) + (ACC_W+1)'(init_q);
      acc_d   = acc_sum[ACC_W-1:0] + ACC_W'(acc_sum[ACC_W]);
   end

   always_comb begin
      fold_x = acc_q;
      for (int unsigned i = 0; i < NCH; i++) begin
         fold_x = ACC_W'(fold_x[15:0]) + (fold_x >> 16);
      end
      s1_d = fold_x[16:0];
   end

   assign s2 = s1_q[15:0] + {15'b0, s1_q[16]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ACCUM;
         in_ready_q   <= 1'b0;
         first_q      <= 1'b1;
         lane_vld_q   <= 1'b0;
         lane_sum_q   <= '0;
         init_q       <= '0;
         acc_q        <= '0;
         s1_q         <= '0;
         csum_q       <= '0;
         csum_valid_q <= 1'b0;
`ifdef INET_CSUM_CHECK_EN
         csum_ok_q    <= 1'b0;
`endif
      end else begin
         lane_vld_q <= accept;
         if (accept) begin
            lane_sum_q <= lane_sum_d;
            init_q     <= first_q ? init_value : '0;
            first_q    <= 1'b0;
         end
         if (lane_vld_q) acc_q <= acc_d;

         case (state_q)
            ACCUM: begin
               in_ready_q <= !(accept && in_last);
               if (accept && in_last) state_q <= DRAIN;
            end
            // Hold until the final lane sum has been absorbed into acc.
            DRAIN: begin
               if (!lane_vld_q) state_q <= FOLD1;
            end
            FOLD1: begin
               s1_q    <= s1_d;
               state_q <= FOLD2;
            end
            FOLD2: begin
               csum_q       <= ~s2;
               csum_valid_q <= 1'b1;
`ifdef INET_CSUM_CHECK_EN
               csum_ok_q    <= (s2 == 16'hFFFF);
`endif
               state_q      <= DONE;
            end
            DONE: begin
               if (csum_ready) begin
                  csum_valid_q <= 1'b0;
`ifdef INET_CSUM_CHECK_EN
                  csum_ok_q    <= 1'b0;
`endif
                  acc_q        <= '0;
                  first_q      <= 1'b1;
                  in_ready_q   <= 1'b1;
                  state_q      <= ACCUM;
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign csum       = csum_q;
   assign csum_valid = csum_valid_q;
`ifdef INET_CSUM_CHECK_EN
   assign csum_ok    = csum_ok_q;
`endif

endmodule
